// File: rtl/playfield_writer.sv
// Write-side front end of the 32x30 playfield tile RAM: tile-coordinate writes
// over valid/ready, plus a full-screen clear sweep (on request or after reset).
module playfield_writer #(
   parameter int                COLS           = 32,
   parameter int                ROWS           = 30,
   parameter int                CODE_W         = 8,
   parameter logic [CODE_W-1:0] CLEAR_CODE     = 8'h00,
   parameter bit                CLEAR_ON_RESET = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear_req,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [4:0]        req_tile_x,
   input  logic [4:0]        req_tile_y,
   input  logic [CODE_W-1:0] req_code,
   output logic              ram_we,
   output logic [9:0]        ram_waddr,
   output logic [CODE_W-1:0] ram_wdata,
   output logic              busy,
   output logic              err,
   output logic              clear_done
);

   localparam logic [9:0] LAST_ADDR = 10'(ROWS * COLS - 1);
   localparam logic [4:0] ROW_LIMIT = 5'(ROWS);

   typedef enum logic {S_IDLE, S_CLEAR} state_t;

   state_t            r_state;
   logic              r_boot;
   logic [9:0]        r_clr_cnt;
   logic              r_we;
   logic [9:0]        r_waddr;
   logic [CODE_W-1:0] r_wdata;
   logic              r_busy;
   logic              r_err;
   logic              r_done;

   logic w_start;
   logic w_accept;

   // r_boot behaves like a clear request on the first edge after reset releases
   assign w_start   = clear_req || r_boot;
   assign req_ready = !rst && (r_state == S_IDLE) && !w_start;
   assign w_accept  = req_valid && req_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_boot    <= CLEAR_ON_RESET;
         r_clr_cnt <= '0;
         r_we      <= 1'b0;
         r_waddr   <= '0;
         r_wdata   <= '0;
         r_busy    <= 1'b0;
         r_err     <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_err  <= 1'b0;
         r_done <= 1'b0;
         r_boot <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_start) begin
                  r_state   <= S_CLEAR;
                  r_busy    <= 1'b1;
                  r_we      <= 1'b1;
                  r_clr_cnt <= '0;
                  r_waddr   <= '0;
                  r_wdata   <= CLEAR_CODE;
               end else if (w_accept) begin
                  if (req_tile_y >= ROW_LIMIT) begin
                     r_we  <= 1'b0;
                     r_err <= 1'b1;
                  end else begin
                     r_we    <= 1'b1;
                     r_waddr <= {req_tile_y, req_tile_x};
                     r_wdata <= req_code;
                  end
               end else begin
                  r_we <= 1'b0;
               end
            end
            S_CLEAR: begin
               // r_clr_cnt is the address currently on the write bus
               if (clear_req) begin
                  r_we      <= 1'b1;
                  r_clr_cnt <= '0;
                  r_waddr   <= '0;
                  r_wdata   <= CLEAR_CODE;
               end else if (r_clr_cnt == LAST_ADDR) begin
                  r_state   <= S_IDLE;
                  r_we      <= 1'b0;
                  r_busy    <= 1'b0;
                  r_done    <= 1'b1;
                  r_clr_cnt <= '0;
               end else begin
                  r_we      <= 1'b1;
                  r_clr_cnt <= r_clr_cnt + 10'd1;
                  r_waddr   <= r_clr_cnt + 10'd1;
                  r_wdata   <= CLEAR_CODE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign ram_we     = r_we;
   assign ram_waddr  = r_waddr;
   assign ram_wdata  = r_wdata;
   assign busy       = r_busy;
   assign err        = r_err;
   assign clear_done = r_done;

endmodule

// File: doc/playfield_writer.md
Name: playfield_writer

Overview:
- Write-side front end of the 32x30 playfield tile RAM, which the display path reads through its pixel-to-tile mapping.
- Accepts tile-coordinate write requests from game logic over a valid/ready handshake and converts them to linear tile RAM addresses (addr = 32*tile_y + tile_x).
- Also runs a full-screen clear sweep, triggered on request or automatically after reset.
- Drives the RAM write port; the video read port is untouched.

Parameters:
- COLS, 32, tiles per row; fixed power of two, address = y*COLS + x.
- ROWS, 30, tile rows; last valid address = ROWS*COLS-1 = 959.
- CODE_W, 8, tile code width.
- CLEAR_CODE, 8'h00, tile code written by the clear sweep.
- CLEAR_ON_RESET, 1, 1 = enter CLEAR on the first cycle after rst deasserts.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- clear_req  input  1  single-cycle pulse: start or restart the clear sweep
- req_valid  input  1  write request present
- req_ready  output  1  request accepted this cycle when req_valid && req_ready
- req_tile_x  input  5  tile column 0..31
- req_tile_y  input  5  tile row 0..29 (30, 31 illegal)
- req_code  input  CODE_W  tile code to store
- ram_we  output  1  tile RAM write enable
- ram_waddr  output  10  tile RAM write address
- ram_wdata  output  CODE_W  tile RAM write data
- busy  output  1  high while in CLEAR
- err  output  1  one-cycle pulse: illegal request was accepted and dropped
- clear_done  output  1  one-cycle pulse after the final clear write

Behaviour:
- Reset, while rst is high: all outputs 0; state is IDLE; clear counter is 0. On the first cycle after deassert, state is CLEAR if CLEAR_ON_RESET=1, otherwise IDLE.
- rst asserted mid-sweep or mid-write aborts immediately; no further ram_we until a new sweep or request.
- All outputs are registered except req_ready.
- States:
  - IDLE: req_ready = !clear_req (combinational); req_ready = 0 in CLEAR.
  - IDLE -> CLEAR on clear_req.
  - CLEAR -> IDLE after address 959 is written.
- Write path, 1-cycle latency:
  - A handshake at edge N gives, in cycle N+1: ram_we=1, ram_waddr = {tile_y, tile_x}, ram_wdata = req_code.
  - Back-to-back requests are accepted every cycle, giving a continuous ram_we.
  - With no handshake, ram_we=0 the next cycle; ram_waddr and ram_wdata hold their last values.
- Illegal request (tile_y >= 30): accepted (ready stays high), no RAM write; err=1 in cycle N+1.
- CLEAR sweep:
  - Counter starts at 0; each cycle ram_we=1, ram_waddr=counter, ram_wdata=CLEAR_CODE; counter increments.
  - Exactly 960 consecutive write cycles, addresses 0..959; counter never reaches 960 on the bus.
  - The cycle after the write to 959: clear_done=1, busy=0, state IDLE, ram_we=0.
  - busy=1 in every sweep write cycle, including the first.
- clear_req and req_valid in the same cycle from IDLE: clear wins; req_ready=0 and the request is not accepted (requester holds it). The sweep's first write (addr 0) appears the next cycle.
- clear_req during CLEAR restarts the sweep: the next write is to address 0, and clear_done is not pulsed for the aborted sweep.
- A request accepted in the cycle before clear_req: its write still completes in the next cycle. The sweep's first write follows one cycle later, so ram_we stays continuous.
- Address arithmetic: 10-bit, no carry possible (y <= 29 gives max 959); x is always legal.

Test Plan:
- Reset with CLEAR_ON_RESET=1, then release -> 960 cycles of ram_we, addresses 0..959 with data 0x00; clear_done pulses once at the cycle after addr 959; busy=0 afterwards; req_ready=0 throughout.
- Idle write, x=5, y=3, code=0x2A -> next cycle ram_we=1, ram_waddr=101, ram_wdata=0x2A; single cycle only.
- Burst of x=31 y=29 code=0x11, then x=0 y=0 code=0x22 on consecutive cycles -> ram_waddr 959 then 0 on consecutive cycles, both with ram_we=1; err never asserts.
- Illegal write y=30, x=7 -> req_ready=1, no ram_we next cycle, err=1 for exactly one cycle.
- Simultaneous clear_req and req_valid (x=2, y=2) -> req_ready=0; next cycle write to addr 0 with CLEAR_CODE. Request held by requester is accepted only after clear_done; its write to addr 66 follows.
- clear_req pulsed at sweep addr 500; separately rst pulsed at sweep addr 300 -> clear_req case: next write is addr 0, total 960 more writes, one clear_done. rst case: ram_we drops to 0 the cycle after reset asserts, then the sweep restarts from 0 (CLEAR_ON_RESET=1).
